// File: rtl/board_pkg.sv
// ----------------------------------------------------------------------------
// board_pkg
// Shared definitions for the board input loader:
//   - mode FSM state encoding
//   - push-button index constants (swb bit positions)
//   - slide-switch field bit positions used by the captures and flag load
//   - packing function for the control word shown on the display
// ----------------------------------------------------------------------------
package board_pkg;

    typedef enum logic [2:0] {
        ST_VIEW_RES  = 3'd0,
        ST_VIEW_A    = 3'd1,
        ST_VIEW_B    = 3'd2,
        ST_VIEW_CTRL = 3'd3,
        ST_EDIT      = 3'd4
    } mode_e;

    localparam int NUM_BTN  = 6;
    localparam int BTN_A    = 0;  // button 1: operand A select / capture
    localparam int BTN_B    = 1;  // button 2: shifter data select / capture
    localparam int BTN_CTRL = 2;  // button 3: control fields select / capture
    localparam int BTN_HOLD = 3;  // button 4 (S): flag hold level
    localparam int BTN_NZCV = 4;  // button 5: flag register load
    localparam int BTN_MODE = 5;  // button 6: EDIT <-> VIEW toggle

    localparam int SW_ALU_MSB  = 31;
    localparam int SW_ALU_LSB  = 28;
    localparam int SW_SOP_MSB  = 26;
    localparam int SW_SOP_LSB  = 24;
    localparam int SW_SNUM_MSB = 23;
    localparam int SW_SNUM_LSB = 16;
    localparam int SW_N        = 24;  // switch 8
    localparam int SW_Z        = 16;  // switch 16
    localparam int SW_C        = 8;   // switch 24
    localparam int SW_V        = 0;   // switch 32

    // Each flag occupies the low bit of its own hex digit so it reads as 0/1
    // on the seven-segment display.
    function automatic logic [31:0] pack_ctrl(
        input logic [3:0] alu_op,
        input logic [2:0] shift_op,
        input logic [7:0] shift_num,
        input logic [3:0] nzcv
    );
        return {alu_op, 1'b0, shift_op, shift_num,
                3'b000, nzcv[3], 3'b000, nzcv[2],
                3'b000, nzcv[1], 3'b000, nzcv[0]};
    endfunction

endpackage

// File: rtl/board_input_loader_btn_debounce.sv
// ----------------------------------------------------------------------------
// btn_debounce
// One push button: 2-FF synchronizer, stability counter and rising-edge pulse.
// Ports:
//   clk, rst_n  : board clock, asynchronous active-low reset
//   i_btn       : raw button level (asynchronous to clk)
//   o_level     : accepted (debounced) level
//   o_press     : one-cycle pulse on each accepted rising edge
// ----------------------------------------------------------------------------
module btn_debounce #(
    parameter int DB_CYCLES = 1_000_000,
    parameter int CNT_W     = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_level,
    output logic o_press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_level_q;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_level_q <= 1'b0;
            r_press   <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= i_btn;
            r_sync2   <= r_sync1;
            r_level_q <= r_level;
            r_press   <= r_level & ~r_level_q;
            // The counter tracks consecutive disagreeing cycles; the last one
            // of the run flips the accepted level.
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_level = r_level;
    assign o_press = r_press;

endmodule

// File: rtl/board_input_loader.sv
// ----------------------------------------------------------------------------
// board_input_loader
// Clocked front end for the test board's slide switches and push buttons.
// Buttons are synchronized, debounced and turned into press pulses; a mode
// FSM captures the switches into operand/control registers (EDIT) or selects
// the word sent to the display driver (VIEW states).
// Ports:
//   clk, rst_n          : board clock, asynchronous active-low reset
//   sw[31:0]            : raw slide switches (sw[31] = switch 1)
//   swb[5:0]            : raw buttons, active-high (swb[0] = button 1)
//   f[31:0], nzcv[3:0]  : ALU result and flags, display sources
//   a_reg, shift_data   : captured operand words
//   alu_op, shift_op,
//   shift_num           : captured control fields
//   flag_hold           : debounced button 4 level
//   nzcv_load, nzcv_val : button 5 pulse and synchronized flag switches
//   edit_mode           : high while in EDIT
//   disp_data           : registered word for the display driver
// ----------------------------------------------------------------------------
module board_input_loader
    import board_pkg::*;
#(
    parameter int DB_CYCLES = 1_000_000,
    parameter int CNT_W     = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] sw,
    input  logic [5:0]  swb,
    input  logic [31:0] f,
    input  logic [3:0]  nzcv,
    output logic [31:0] a_reg,
    output logic [31:0] shift_data,
    output logic [3:0]  alu_op,
    output logic [2:0]  shift_op,
    output logic [7:0]  shift_num,
    output logic        flag_hold,
    output logic        nzcv_load,
    output logic [3:0]  nzcv_val,
    output logic        edit_mode,
    output logic [31:0] disp_data
);

    logic [31:0]        r_sw_s1;
    logic [31:0]        r_sw_s2;
    logic [NUM_BTN-1:0] w_level;
    logic [NUM_BTN-1:0] w_press;

    mode_e       r_state;
    logic        r_edit_mode;
    logic [31:0] r_a_reg;
    logic [31:0] r_shift_data;
    logic [3:0]  r_alu_op;
    logic [2:0]  r_shift_op;
    logic [7:0]  r_shift_num;
    logic [31:0] r_disp_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sw_s1 <= '0;
            r_sw_s2 <= '0;
        end else begin
            r_sw_s1 <= sw;
            r_sw_s2 <= r_sw_s1;
        end
    end

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        btn_debounce #(
            .DB_CYCLES (DB_CYCLES),
            .CNT_W     (CNT_W)
        ) u_db (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_btn   (swb[g]),
            .o_level (w_level[g]),
            .o_press (w_press[g])
        );
    end

    // Captures and selections are decided from the state held before this
    // edge; the mode button still toggles in the same cycle and its target
    // state overrides any selection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_VIEW_RES;
            r_edit_mode  <= 1'b0;
            r_a_reg      <= '0;
            r_shift_data <= '0;
            r_alu_op     <= '0;
            r_shift_op   <= '0;
            r_shift_num  <= '0;
            r_disp_data  <= '0;
        end else begin
            if (r_state == ST_EDIT) begin
                if (w_press[BTN_A]) begin
                    r_a_reg <= r_sw_s2;
                end else if (w_press[BTN_B]) begin
                    r_shift_data <= r_sw_s2;
                end else if (w_press[BTN_CTRL]) begin
                    r_alu_op    <= r_sw_s2[SW_ALU_MSB:SW_ALU_LSB];
                    r_shift_op  <= r_sw_s2[SW_SOP_MSB:SW_SOP_LSB];
                    r_shift_num <= r_sw_s2[SW_SNUM_MSB:SW_SNUM_LSB];
                end
                if (w_press[BTN_MODE]) begin
                    r_state     <= ST_VIEW_RES;
                    r_edit_mode <= 1'b0;
                end
            end else begin
                if (w_press[BTN_MODE]) begin
                    r_state     <= ST_EDIT;
                    r_edit_mode <= 1'b1;
                end else if (w_press[BTN_A]) begin
                    r_state <= ST_VIEW_A;
                end else if (w_press[BTN_B]) begin
                    r_state <= ST_VIEW_B;
                end else if (w_press[BTN_CTRL]) begin
                    r_state <= ST_VIEW_CTRL;
                end
            end

            case (r_state)
                ST_VIEW_A:    r_disp_data <= r_a_reg;
                ST_VIEW_B:    r_disp_data <= r_shift_data;
                ST_VIEW_CTRL: r_disp_data <= pack_ctrl(r_alu_op, r_shift_op,
                                                       r_shift_num, nzcv);
                ST_EDIT:      r_disp_data <= r_sw_s2;
                default:      r_disp_data <= f;
            endcase
        end
    end

    assign a_reg      = r_a_reg;
    assign shift_data = r_shift_data;
    assign alu_op     = r_alu_op;
    assign shift_op   = r_shift_op;
    assign shift_num  = r_shift_num;
    assign flag_hold  = w_level[BTN_HOLD];
    assign nzcv_load  = w_press[BTN_NZCV];
    assign nzcv_val   = {r_sw_s2[SW_N], r_sw_s2[SW_Z], r_sw_s2[SW_C], r_sw_s2[SW_V]};
    assign edit_mode  = r_edit_mode;
    assign disp_data  = r_disp_data;

endmodule

// File: tb/tb_board_input_loader.sv
module tb_board_input_loader;

    localparam int DB = 4;
    localparam int CW = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] sw;
    logic [5:0]  swb;
    logic [31:0] f;
    logic [3:0]  nzcv;
    logic [31:0] a_reg, shift_data, disp_data;
    logic [3:0]  alu_op, nzcv_val;
    logic [2:0]  shift_op;
    logic [7:0]  shift_num;
    logic        flag_hold, nzcv_load, edit_mode;

    int checks = 0;
    int errors = 0;

    // Reference model: 0 = show result, 1 = A, 2 = B, 3 = ctrl, 4 = edit
    int          m_state;
    logic [31:0] m_a, m_sd;
    logic [3:0]  m_alu;
    logic [2:0]  m_sop;
    logic [7:0]  m_snum;

    // Observations from the last button operation
    int          o_cnt, o_at, o_rise, o_fall;
    logic [3:0]  o_val;

    board_input_loader #(.DB_CYCLES(DB), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sw         (sw),
        .swb        (swb),
        .f          (f),
        .nzcv       (nzcv),
        .a_reg      (a_reg),
        .shift_data (shift_data),
        .alu_op     (alu_op),
        .shift_op   (shift_op),
        .shift_num  (shift_num),
        .flag_hold  (flag_hold),
        .nzcv_load  (nzcv_load),
        .nzcv_val   (nzcv_val),
        .edit_mode  (edit_mode),
        .disp_data  (disp_data)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    function automatic void model_reset();
        m_state = 0;
        m_a = '0; m_sd = '0; m_alu = '0; m_sop = '0; m_snum = '0;
    endfunction

    function automatic void model_press(input logic [5:0] m);
        int old;
        old = m_state;
        if (old == 4) begin
            if (m[0]) m_a = sw;
            else if (m[1]) m_sd = sw;
            else if (m[2]) begin
                m_alu = sw[31:28]; m_sop = sw[26:24]; m_snum = sw[23:16];
            end
            if (m[5]) m_state = 0;
        end else begin
            if (m[0]) m_state = 1;
            else if (m[1]) m_state = 2;
            else if (m[2]) m_state = 3;
            if (m[5]) m_state = 4;
        end
    endfunction

    function automatic logic [31:0] exp_disp();
        case (m_state)
            1: return m_a;
            2: return m_sd;
            3: return {m_alu, 1'b0, m_sop, m_snum, 3'b0, nzcv[3], 3'b0, nzcv[2],
                       3'b0, nzcv[1], 3'b0, nzcv[0]};
            4: return sw;
            default: return f;
        endcase
    endfunction

    // Called at a negedge: raise the masked buttons cleanly for 12 cycles,
    // release for 12 cycles, recording pulse/level timing relative to each edge.
    task automatic do_op(input logic [5:0] mask);
        o_cnt = 0; o_at = -1; o_val = '0; o_rise = -1; o_fall = -1;
        swb = mask;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (nzcv_load === 1'b1) begin
                o_cnt++;
                if (o_at < 0) begin o_at = i; o_val = nzcv_val; end
            end
            if (flag_hold === 1'b1 && o_rise < 0) o_rise = i;
        end
        swb = '0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (nzcv_load === 1'b1) o_cnt++;
            if (flag_hold !== 1'b1 && o_fall < 0) o_fall = i;
        end
        model_press(mask);
    endtask

    task automatic set_sw(input logic [31:0] v);
        sw = v;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; swb = '0; sw = '0; nzcv = '0; f = 32'h1234_5678;
        repeat (3) @(negedge clk);
        checks++; if (a_reg !== 32'h0) begin errors++; $display("FAIL reset_a_reg got %h want 0", a_reg); end
        checks++; if (shift_data !== 32'h0) begin errors++; $display("FAIL reset_shift_data got %h want 0", shift_data); end
        checks++; if ({alu_op, shift_op, shift_num} !== 15'h0) begin errors++; $display("FAIL reset_ctrl got %h want 0", {alu_op, shift_op, shift_num}); end
        checks++; if ({flag_hold, nzcv_load, edit_mode, nzcv_val} !== 7'h0) begin errors++; $display("FAIL reset_flags got %b want 0", {flag_hold, nzcv_load, edit_mode, nzcv_val}); end
        checks++; if (disp_data !== 32'h0) begin errors++; $display("FAIL reset_disp got %h want 0", disp_data); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (disp_data !== 32'h1234_5678) begin errors++; $display("FAIL reset_release_disp got %h want 12345678", disp_data); end
        model_reset();
    endtask

    task automatic test_capture_a();
        do_op(6'h20);
        checks++; if (edit_mode !== 1'b1) begin errors++; $display("FAIL enter_edit got %b want 1", edit_mode); end
        set_sw(32'hDEAD_BEEF);
        do_op(6'h01);
        do_op(6'h20);
        do_op(6'h01);
        checks++; if (a_reg !== 32'hDEAD_BEEF) begin errors++; $display("FAIL capture_a got %h want deadbeef", a_reg); end
        checks++; if (edit_mode !== 1'b0) begin errors++; $display("FAIL view_a_mode got %b want 0", edit_mode); end
        checks++; if (disp_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL view_a_disp got %h want deadbeef", disp_data); end
    endtask

    task automatic test_capture_ctrl();
        do_op(6'h20);
        set_sw(32'h5A34_0000);
        do_op(6'h04);
        checks++; if (alu_op !== 4'd5) begin errors++; $display("FAIL alu_op got %h want 5", alu_op); end
        checks++; if (shift_op !== 3'd2) begin errors++; $display("FAIL shift_op got %h want 2", shift_op); end
        checks++; if (shift_num !== 8'h34) begin errors++; $display("FAIL shift_num got %h want 34", shift_num); end
        checks++; if (disp_data !== 32'h5A34_0000) begin errors++; $display("FAIL edit_live_disp got %h want 5a340000", disp_data); end
        nzcv = 4'b1010;
        do_op(6'h20);
        do_op(6'h04);
        checks++; if (disp_data !== 32'h5234_1010) begin errors++; $display("FAIL ctrl_disp got %h want 52341010", disp_data); end
    endtask

    task automatic test_bounce();
        int first;
        first = -1;
        do_op(6'h20);
        set_sw(32'h3C3C_A5A5);
        for (int k = 0; k < 2; k++) begin
            swb[1] = 1'b1; repeat (3) @(negedge clk);
            swb[1] = 1'b0; repeat (3) @(negedge clk);
        end
        swb[1] = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (first < 0 && shift_data === 32'h3C3C_A5A5) first = i;
            if (i == 12) sw = 32'h0F0F_1234;
        end
        checks++; if (first !== 8) begin errors++; $display("FAIL bounce_capture_cycle got %0d want 8", first); end
        swb[1] = 1'b0;
        repeat (12) @(negedge clk);
        checks++; if (shift_data !== 32'h3C3C_A5A5) begin errors++; $display("FAIL bounce_single_press got %h want 3c3ca5a5", shift_data); end
        checks++; if (disp_data !== 32'h0F0F_1234) begin errors++; $display("FAIL bounce_live_disp got %h want 0f0f1234", disp_data); end
        m_sd = 32'h3C3C_A5A5;
    endtask

    task automatic test_flags();
        set_sw(32'h0100_0001);
        do_op(6'h10);
        checks++; if (o_cnt !== 1) begin errors++; $display("FAIL nzcv_load_count got %0d want 1", o_cnt); end
        checks++; if (o_at !== 7) begin errors++; $display("FAIL nzcv_load_cycle got %0d want 7", o_at); end
        checks++; if (o_val !== 4'b1001) begin errors++; $display("FAIL nzcv_val got %b want 1001", o_val); end
        do_op(6'h08);
        checks++; if (o_rise !== 6) begin errors++; $display("FAIL flag_hold_rise got %0d want 6", o_rise); end
        checks++; if (o_fall !== 6) begin errors++; $display("FAIL flag_hold_fall got %0d want 6", o_fall); end
    endtask

    task automatic test_simultaneous();
        logic [31:0] old_sd;
        old_sd = shift_data;
        set_sw(32'h7777_1111);
        do_op(6'h03);
        checks++; if (a_reg !== 32'h7777_1111) begin errors++; $display("FAIL simul_a got %h want 77771111", a_reg); end
        checks++; if (shift_data !== old_sd) begin errors++; $display("FAIL simul_b_untouched got %h want %h", shift_data, old_sd); end
        checks++; if (edit_mode !== 1'b1) begin errors++; $display("FAIL simul_mode got %b want 1", edit_mode); end
    endtask

    task automatic test_reset_mid_hold();
        int cnt, at;
        cnt = 0; at = -1;
        swb = 6'b010001;
        repeat (8) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({a_reg, shift_data, disp_data} !== 96'h0) begin errors++; $display("FAIL async_reset_words got %h want 0", {a_reg, shift_data, disp_data}); end
        checks++; if ({alu_op, shift_op, shift_num, flag_hold, nzcv_load, edit_mode} !== 18'h0) begin errors++; $display("FAIL async_reset_ctrl got %h want 0", {alu_op, shift_op, shift_num, flag_hold, nzcv_load, edit_mode}); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (nzcv_load === 1'b1) begin cnt++; if (at < 0) at = i; end
        end
        checks++; if (cnt !== 1 || at !== 7) begin errors++; $display("FAIL held_through_reset got cnt %0d at %0d want cnt 1 at 7", cnt, at); end
        swb = '0;
        repeat (12) @(negedge clk);
        model_press(6'b010001);
        checks++; if (disp_data !== exp_disp()) begin errors++; $display("FAIL post_reset_disp got %h want %h", disp_data, exp_disp()); end
    endtask

    task automatic test_random();
        logic [5:0] mask;
        for (int n = 0; n < 30; n++) begin
            f = $urandom();
            nzcv = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) set_sw($urandom());
            mask = 6'($urandom_range(1, 63));
            do_op(mask);
            checks++; if (a_reg !== m_a) begin errors++; $display("FAIL rnd%0d a_reg got %h want %h", n, a_reg, m_a); end
            checks++; if (shift_data !== m_sd) begin errors++; $display("FAIL rnd%0d shift_data got %h want %h", n, shift_data, m_sd); end
            checks++; if ({alu_op, shift_op, shift_num} !== {m_alu, m_sop, m_snum}) begin errors++; $display("FAIL rnd%0d ctrl got %h want %h", n, {alu_op, shift_op, shift_num}, {m_alu, m_sop, m_snum}); end
            checks++; if (edit_mode !== (m_state == 4)) begin errors++; $display("FAIL rnd%0d edit_mode got %b want %b", n, edit_mode, (m_state == 4)); end
            checks++; if (disp_data !== exp_disp()) begin errors++; $display("FAIL rnd%0d disp got %h want %h", n, disp_data, exp_disp()); end
            checks++;
            if (mask[4]) begin
                if (o_cnt !== 1 || o_at !== 7 || o_val !== {sw[24], sw[16], sw[8], sw[0]}) begin
                    errors++; $display("FAIL rnd%0d nzcv_load got cnt %0d at %0d val %b want 1 7 %b", n, o_cnt, o_at, o_val, {sw[24], sw[16], sw[8], sw[0]});
                end
            end else if (o_cnt !== 0) begin
                errors++; $display("FAIL rnd%0d nzcv_load got cnt %0d want 0", n, o_cnt);
            end
            checks++;
            if (mask[3]) begin
                if (o_rise !== 6 || o_fall !== 6) begin
                    errors++; $display("FAIL rnd%0d flag_hold got rise %0d fall %0d want 6 6", n, o_rise, o_fall);
                end
            end else if (o_rise !== -1) begin
                errors++; $display("FAIL rnd%0d flag_hold got rise %0d want none", n, o_rise);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        swb = '0; sw = '0; nzcv = '0; f = 32'h1234_5678;
        model_reset();
        test_reset();
        test_capture_a();
        test_capture_ctrl();
        test_bounce();
        test_flags();
        test_simultaneous();
        test_reset_mid_hold();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
